cart_banked: RTL and testbench

Parametrised next-generation cartridge slot for the SCV core that supports bank switching.
- Maps the 32 KB cartridge bus window onto a ROM of up to 2^ROM_AW bytes through a fixed 16 KB window and a switchable 16 KB window.
- Provides optional write-enable-gated battery RAM.
- Tracks the size of the loaded image so small ROMs mirror correctly.
- Sits between the CPU bus and the ROM loader.

---
 rtl/scv_pkg.sv | 14 +
 rtl/cart_spram.sv | 35 +++
 rtl/cart_banked.sv | 158 +++++++++++++++
 tb/tb_cart_banked.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scv_pkg.sv
// Shared SCV core types: cartridge mapper modes and cartridge window geometry.
package scv_pkg;

    typedef enum logic [1:0] {
        BANK_NONE,
        BANK_PORT,
        BANK_REG,
        BANK_REG_RAM
    } bank_mode_t;

    // Each cartridge window (fixed and switchable) spans 2^14 bytes.
    localparam int CART_WIN_AW = 14;

endpackage

// File: rtl/cart_spram.sv
// Generic synchronous single-port RAM with registered, read-enabled output.
module cart_spram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    // Array has no reset so contents survive a reset pulse.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cart_banked.sv
// Bank-switching cartridge slot: fixed + switchable 16 KB ROM windows,
// optional battery RAM, and loaded-size mirroring through rom_mask.
module cart_banked
    import scv_pkg::*;
#(
    parameter int ROM_AW = 19,
    parameter int RAM_AW = 13,
    parameter int BANK_W = 5
) (
    input  logic              CLK,
    input  logic              RESB,
    input  logic [ROM_AW-1:0] INIT_ADDR,
    input  logic [7:0]        INIT_DATA,
    input  logic              INIT_VALID,
    input  bank_mode_t        MODE,
    input  logic [14:0]       A,
    input  logic [7:0]        DB_I,
    output logic [7:0]        DB_O,
    output logic              DB_OE,
    input  logic              RDB,
    input  logic              WRB,
    input  logic              CSB,
    input  logic [6:5]        PC
);

    localparam int FULL_AW = BANK_W + CART_WIN_AW;

    function automatic logic [ROM_AW-1:0] smear(input logic [ROM_AW-1:0] v);
        logic [ROM_AW-1:0] s;
        s = v;
        s = s | (s >> 1);
        s = s | (s >> 2);
        s = s | (s >> 4);
        s = s | (s >> 8);
        s = s | (s >> 16);
        return s;
    endfunction

    logic [BANK_W-1:0] r_bank;
    logic              r_ram_en;
    logic              r_wrb_d;
    logic              r_wr_armed;
    logic              r_rd_ram;
    logic [ROM_AW-1:0] r_rom_mask_n;

    logic [BANK_W-1:0]  w_bank;
    logic [FULL_AW-1:0] w_rom_a_full;
    logic [ROM_AW-1:0]  w_rom_mask;
    logic [ROM_AW-1:0]  w_rom_addr;
    logic [ROM_AW-1:0]  w_rom_port_addr;
    logic               w_ram_sel;
    logic               w_rd;
    logic               w_rd_rom;
    logic               w_rd_ram;
    logic               w_wr_pulse;
    logic [7:0]         w_rom_q;
    logic [7:0]         w_ram_q;

    // Mask is held inverted so an all-zero power-up state means a full mask.
    assign w_rom_mask = ~r_rom_mask_n;

    always_ff @(posedge CLK) begin
        if (INIT_VALID) begin
            r_rom_mask_n <= ~(((INIT_ADDR == '0) ? '0 : w_rom_mask) | smear(INIT_ADDR));
        end
    end

    always_comb begin
        w_bank = '0;
        case (MODE)
            BANK_NONE:    w_bank = BANK_W'(1);
            BANK_PORT:    w_bank = {{(BANK_W-2){1'b0}}, PC};
            BANK_REG,
            BANK_REG_RAM: w_bank = r_bank;
            default:      w_bank = '0;
        endcase
    end

    assign w_rom_a_full = A[14] ? {w_bank, A[CART_WIN_AW-1:0]}
                                : {{BANK_W{1'b0}}, A[CART_WIN_AW-1:0]};
    assign w_rom_addr   = w_rom_a_full[ROM_AW-1:0] & w_rom_mask;
    assign w_ram_sel    = (MODE == BANK_REG_RAM) && (A[14:13] == 2'b11) && r_ram_en;

    assign w_rd       = ~CSB & ~RDB;
    assign w_rd_rom   = w_rd & ~w_ram_sel & ~INIT_VALID;
    assign w_rd_ram   = w_rd & w_ram_sel;
    assign DB_OE      = w_rd;

    // Armed only after WRB is seen high, so a WRB held low across reset
    // release cannot masquerade as a falling edge.
    assign w_wr_pulse = r_wrb_d & r_wr_armed & ~WRB & ~CSB;

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_wrb_d    <= 1'b1;
            r_wr_armed <= 1'b0;
        end else begin
            r_wrb_d    <= WRB;
            if (WRB) begin
                r_wr_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_bank   <= '0;
            r_ram_en <= 1'b0;
        end else if (w_wr_pulse && !w_ram_sel) begin
            if (MODE == BANK_REG || MODE == BANK_REG_RAM) begin
                r_bank <= DB_I[BANK_W-1:0];
            end
            if (MODE == BANK_REG_RAM) begin
                r_ram_en <= DB_I[7];
            end
        end
    end

    // Remembers which memory produced the current DB_O so it holds between reads.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            r_rd_ram <= 1'b0;
        end else if (w_rd_rom || w_rd_ram) begin
            r_rd_ram <= w_rd_ram;
        end
    end

    assign w_rom_port_addr = INIT_VALID ? INIT_ADDR : w_rom_addr;

    cart_spram #(
        .AW (ROM_AW),
        .DW (8)
    ) u_rom (
        .i_clk   (CLK),
        .i_rst_n (RESB),
        .i_we    (INIT_VALID),
        .i_re    (w_rd_rom),
        .i_addr  (w_rom_port_addr),
        .i_wdata (INIT_DATA),
        .o_rdata (w_rom_q)
    );

    cart_spram #(
        .AW (RAM_AW),
        .DW (8)
    ) u_ram (
        .i_clk   (CLK),
        .i_rst_n (RESB),
        .i_we    (w_wr_pulse & w_ram_sel),
        .i_re    (w_rd_ram),
        .i_addr  (A[RAM_AW-1:0]),
        .i_wdata (DB_I),
        .o_rdata (w_ram_q)
    );

    assign DB_O = r_rd_ram ? w_ram_q : w_rom_q;

endmodule

// File: tb/tb_cart_banked.sv
// Directed testbench for cart_banked with hand-computed expected read data.
module tb_cart_banked;
  import scv_pkg::*;

  logic        CLK;
  logic        RESB;
  logic [18:0] INIT_ADDR;
  logic [7:0]  INIT_DATA;
  logic        INIT_VALID;
  bank_mode_t  MODE;
  logic [14:0] A;
  logic [7:0]  DB_I;
  logic [7:0]  DB_O;
  logic        DB_OE;
  logic        RDB;
  logic        WRB;
  logic        CSB;
  logic [6:5]  PC;

  int n_vec;
  int n_err;

  // ROM locations touched by the directed reads; only these get loaded.
  int pts[11] = '{32'h00010, 32'h04001, 32'h04010, 32'h07FFF, 32'h08000,
                  32'h08010, 32'h0BFFF, 32'h0C010, 32'h14000, 32'h14010,
                  32'h02003};

  cart_banked dut (
    .CLK        (CLK),
    .RESB       (RESB),
    .INIT_ADDR  (INIT_ADDR),
    .INIT_DATA  (INIT_DATA),
    .INIT_VALID (INIT_VALID),
    .MODE       (MODE),
    .A          (A),
    .DB_I       (DB_I),
    .DB_O       (DB_O),
    .DB_OE      (DB_OE),
    .RDB        (RDB),
    .WRB        (WRB),
    .CSB        (CSB),
    .PC         (PC)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] img(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_byte(input logic [18:0] a);
    INIT_VALID = 1'b1;
    INIT_ADDR  = a;
    INIT_DATA  = img(a);
    tick();
    INIT_VALID = 1'b0;
  endtask

  task automatic load_image(input int size);
    load_byte(19'h0);
    foreach (pts[i]) begin
      if (pts[i] < size) load_byte(pts[i][18:0]);
    end
    load_byte(19'(size - 1));
  endtask

  task automatic cpu_wr(input logic [14:0] addr, input logic [7:0] data);
    A    = addr;
    DB_I = data;
    CSB  = 1'b0;
    WRB  = 1'b0;
    tick();
    WRB  = 1'b1;
    CSB  = 1'b1;
    tick();
  endtask

  task automatic cpu_rd(input string tag, input logic [14:0] addr, input logic [7:0] exp);
    A   = addr;
    CSB = 1'b0;
    RDB = 1'b0;
    tick();
    check(tag, DB_O, exp);
    RDB = 1'b1;
    CSB = 1'b1;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    RESB       = 1'b0;
    INIT_ADDR  = '0;
    INIT_DATA  = '0;
    INIT_VALID = 1'b0;
    MODE       = BANK_NONE;
    A          = '0;
    DB_I       = '0;
    RDB        = 1'b1;
    WRB        = 1'b1;
    CSB        = 1'b1;
    PC         = 2'b00;
    #17;
    check("rst_db_o", DB_O, 8'h00);
    check("rst_db_oe", DB_OE, 1'b0);
    RESB = 1'b1;
    tick();

    // 1: linear 32 KB image
    load_image(32'h8000);
    MODE = BANK_NONE;
    A = 15'h4001;
    CSB = 1'b0;
    #1 check("oe_csb_only", DB_OE, 1'b0);
    RDB = 1'b0;
    #1 check("oe_both_low", DB_OE, 1'b1);
    check("db_o_before_edge", DB_O, 8'h00);
    tick();
    check("none_4001", DB_O, 8'h41);
    RDB = 1'b1;
    #1 check("oe_rdb_high", DB_OE, 1'b0);
    CSB = 1'b1;
    A = 15'h0010;
    tick();
    check("hold_db_o", DB_O, 8'h41);
    A = 15'h0010;
    CSB = 1'b0;
    RDB = 1'b0;
    INIT_VALID = 1'b1;
    INIT_ADDR  = 19'h00010;
    INIT_DATA  = img(19'h00010);
    tick();
    check("init_wins_stale", DB_O, 8'h41);
    INIT_VALID = 1'b0;
    tick();
    check("none_0010", DB_O, 8'h10);
    RDB = 1'b1;
    CSB = 1'b1;
    tick();

    // 2: 128 KB, register banking
    load_image(32'h20000);
    MODE = BANK_REG;
    cpu_wr(15'h0000, 8'h05);
    cpu_rd("reg_b5_4000", 15'h4000, 8'h41);
    cpu_rd("reg_fixed_0010", 15'h0010, 8'h10);
    A = 15'h0000;
    DB_I = 8'h05;
    CSB = 1'b0;
    WRB = 1'b0;
    tick();
    DB_I = 8'h02;
    for (int i = 0; i < 9; i++) tick();
    WRB = 1'b1;
    CSB = 1'b1;
    tick();
    cpu_rd("held_wrb_once", 15'h4010, 8'h51);
    A = 15'h4000;
    DB_I = 8'h02;
    CSB = 1'b0;
    RDB = 1'b0;
    WRB = 1'b0;
    tick();
    check("wr_rd_old_bank", DB_O, 8'h41);
    tick();
    check("wr_rd_new_bank", DB_O, 8'h80);
    WRB = 1'b1;
    RDB = 1'b1;
    CSB = 1'b1;
    tick();

    // 3: 64 KB image mirrors high banks
    load_image(32'h10000);
    cpu_wr(15'h0000, 8'h07);
    cpu_rd("mirror_b7", 15'h4010, 8'hD0);

    // 4: port-driven banking
    MODE = BANK_PORT;
    PC = 2'b10;
    cpu_rd("port_7fff", 15'h7FFF, 8'h40);
    cpu_wr(15'h0000, 8'h01);
    cpu_rd("port_ignores_wr", 15'h7FFF, 8'h40);
    PC = 2'b01;
    cpu_rd("port_pc01", 15'h4010, 8'h50);

    // 5: register banking with battery RAM
    RESB = 1'b0;
    #2;
    RESB = 1'b1;
    tick();
    MODE = BANK_REG_RAM;
    cpu_wr(15'h6000, 8'hAA);
    cpu_rd("regram_bank_0a", 15'h4010, 8'h90);
    cpu_wr(15'h6003, 8'h5A);
    cpu_rd("ram_readback", 15'h6003, 8'h5A);
    cpu_rd("ram_wr_kept_bank", 15'h4010, 8'h90);
    RESB = 1'b0;
    #2 check("rst_mid_db_o", DB_O, 8'h00);
    RESB = 1'b1;
    tick();
    cpu_rd("rst_ram_off", 15'h6003, 8'h23);
    cpu_wr(15'h0000, 8'h80);
    cpu_rd("ram_retained", 15'h6003, 8'h5A);

    // 6: WRB held low through reset release
    A = 15'h0000;
    DB_I = 8'h83;
    CSB = 1'b0;
    WRB = 1'b0;
    RESB = 1'b0;
    tick();
    tick();
    RESB = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    A = 15'h6003;
    RDB = 1'b0;
    tick();
    check("no_wr_after_rst", DB_O, 8'h23);
    RDB = 1'b1;
    A = 15'h0000;
    WRB = 1'b1;
    tick();
    DB_I = 8'h81;
    WRB = 1'b0;
    tick();
    WRB = 1'b1;
    CSB = 1'b1;
    tick();
    cpu_rd("rearm_ram_on", 15'h6003, 8'h5A);
    cpu_rd("rearm_bank_1", 15'h4010, 8'h50);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
